shift_rx: RTL
=============

Name: shift_rx

Overview:
- Serial-to-parallel frame receiver. It is the receiving end of the serial link driven by the team's 74x194-style universal shift register running in shift mode.
- Samples a bit-strobed serial line and detects start, data and stop bits. Assembles WIDTH data bits into a parallel word.
- Presents the word through a valid/ready holding register, with framing-error and overrun reporting.

Parameters:
- WIDTH, 4, number of data bits per frame (>=2).
- MSB_FIRST, 1, 1 = first data bit received is DOUT[WIDTH-1]; 0 = first data bit is DOUT[0].

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- SIN  input  1  serial data line; idles high.
- SEN  input  1  bit strobe; SIN is sampled only on cycles with SEN=1.
- DREADY  input  1  consumer accepts DOUT when DVALID=1 in the same cycle.
- DOUT  output  WIDTH  received word (holding register).
- DVALID  output  1  DOUT holds an unconsumed word.
- BUSY  output  1  a frame is in progress (state is not IDLE).
- FERR  output  1  one-cycle pulse: stop bit sampled low.
- OVR  output  1  sticky: a complete frame was dropped because the holding register was full.

Behaviour:
- Reset: one clock with CLR=1 forces state=IDLE, bit counter=0, shift register=0, DOUT=0, DVALID=0, BUSY=0, FERR=0, OVR=0.
  - CLR overrides every other input and aborts any frame in progress; the partial frame is discarded.
- States: IDLE, DATA, STOP, RECOVER. Cycles with SEN=0 change nothing except the DVALID handshake.
- IDLE:
  - SEN=1 and SIN=0 (start bit): go to DATA, counter=0.
  - SEN=1 and SIN=1: stay in IDLE.
- DATA, on each SEN=1:
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
  - Counter increments. After the WIDTH-th bit (counter==WIDTH-1 at the strobe) go to STOP.
- STOP, on SEN=1:
  - SIN=1 (valid frame):
    - If DVALID=0, or DREADY=1 this cycle: DOUT<=shift register, DVALID<=1.
    - Otherwise the word is dropped and OVR<=1.
    - Go to IDLE.
  - SIN=0 (framing error): FERR=1 for exactly the next cycle, word discarded, go to RECOVER.
- RECOVER: on SEN=1 with SIN=1 go to IDLE. A line held low (break) therefore never produces spurious frames.
- BUSY=1 in DATA, STOP and RECOVER.
- Output handshake:
  - Transfer occurs on any cycle with DVALID=1 and DREADY=1.
  - With no new load that cycle, DVALID<=0 at the edge.
  - If the transfer and a valid stop bit happen together, the new word loads, DVALID stays 1 and OVR is not set.
  - DOUT is stable while DVALID=1 and not transferred.
  - DOUT keeps its last value after DVALID falls.
- Latency: DVALID and the new DOUT are visible in the cycle after the clock edge that sampled the stop bit.
- Back-to-back frames: a start bit may be sampled on the very next strobe after the stop bit.
- OVR clears only on CLR.
- A frame in flight continues unaffected by DVALID/DREADY activity.
- Data bits are taken exactly as sampled, with no majority voting or oversampling. Strobe timing is the sender's responsibility.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, DREADY=0; strobe SIN=0,1,0,1,0,1 (SEN=1 every other cycle) -> DOUT=4'b1010 and DVALID=1 one cycle after the stop edge; BUSY high from start through stop; FERR=0, OVR=0.
2. MSB_FIRST=0, same bit sequence -> DOUT=4'b0101. Then raise DREADY for one cycle -> DVALID=0 next cycle, DOUT stays 4'b0101.
3. With DVALID=1 and DREADY=0, send frame 0,1,1,1,1,1 -> DOUT remains the old word, OVR=1 and stays 1. Repeat with DREADY=1 on the stop-bit cycle -> DOUT=4'b1111, DVALID stays 1, no OVR.
4. Send 0,1,1,0,0,0 (stop low) -> FERR high for exactly one cycle, DVALID unchanged. Hold SIN=0 for 5 strobes -> no new frame, BUSY=1. Then SIN=1 strobe -> IDLE, BUSY=0; a following good frame 0,0,0,1,1,1 -> DOUT=4'b0011.
5. Assert CLR for one cycle after the 2nd data bit -> all outputs 0 next cycle, including OVR. A subsequent full frame 0,1,1,0,0,1 -> DOUT=4'b1100 correctly.
6. Back-to-back frames with SEN every cycle and DREADY=1: 0,1,0,0,1,1 then 0,0,1,1,0,1 -> DOUT=4'b1001 followed by 4'b0110, no OVR, no FERR.

Source files
------------

// File: rtl/shift_rx.sv
// Purpose: serial-to-parallel frame receiver (start bit, WIDTH data bits, stop bit) sampled on a bit strobe.
// Latency: dout/dvalid update on the edge that samples a good stop bit, visible the following cycle.
// Backpressure: a one-word holding register, dvalid/dready. A good frame that finds it full is dropped and sets sticky ovr.
//
// Ports:
//   clk    - system clock, rising edge
//   clr    - synchronous active-high reset; aborts any frame in progress
//   sin    - serial data line, idles high
//   sen    - bit strobe; sin is sampled only when sen=1
//   dready - consumer accepts dout when dvalid=1 in the same cycle
//   dout   - received word (holding register)
//   dvalid - dout holds an unconsumed word
//   busy   - frame in progress (DATA, STOP or RECOVER)
//   ferr   - one-cycle pulse: the stop bit was sampled low
//   ovr    - sticky: a complete frame was dropped because the holding register was full
module shift_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sen,
  input  logic             dready,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             busy,
  output logic             ferr,
  output logic             ovr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
  localparam logic [1:0] STOP    = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             good_stop;
  logic             load;

  // Next shift-register value if a data bit is taken this cycle.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST)
      shreg_nxt = {shreg[WIDTH-2:0], sin};
    else
      shreg_nxt = {sin, shreg[WIDTH-1:1]};
  end

  // A good stop bit may load even when dvalid is set, provided the old
  // word is being handed off on this very edge.
  always_comb begin
    good_stop = sen && (state == STOP) && sin;
    load      = good_stop && (!dvalid || dready);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      ferr <= 1'b0;

      if (sen) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= shreg_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST)
              state <= STOP;
          end
          STOP: begin
            if (sin) begin
              if (!load)
                ovr <= 1'b1;
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= RECOVER;
            end
          end
          default: begin
            // Wait for the line to return high so a held-low line never
            // looks like a run of start bits.
            if (sin)
              state <= IDLE;
          end
        endcase
      end

      // Holding register: a load wins over a simultaneous transfer.
      if (load) begin
        dout   <= shreg;
        dvalid <= 1'b1;
      end else if (dvalid && dready) begin
        dvalid <= 1'b0;
      end
    end
  end

endmodule
